// File: rtl/aes_pkg.sv
// Shared AES output-path definitions: default widths, serializer FSM state
// type and lane-count helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } aes_state_e;

  function automatic int lane_count(input int block_w, input int lane_w);
    return block_w / lane_w;
  endfunction

endpackage

// File: rtl/aes_lane_sel.sv
// Combinational lane selector: picks lane i_idx out of a block, counting
// lanes from the MSB end or the LSB end depending on MSB_FIRST.
module aes_lane_sel
  import aes_pkg::*;
#(
  parameter int BLOCK_W   = AES_BLOCK_W,
  parameter int LANE_W    = AES_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [BLOCK_W-1:0]                              i_block,
  input  logic [$clog2(lane_count(BLOCK_W, LANE_W))-1:0] i_idx,
  output logic [LANE_W-1:0]                               o_lane
);

  localparam int NLANES = lane_count(BLOCK_W, LANE_W);

  // Unrolled mux keeps every part-select constant, so no index arithmetic
  // can ever reach outside the block.
  always_comb begin
    o_lane = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (int'(i_idx) == i) begin
        if (MSB_FIRST) o_lane = i_block[BLOCK_W-1-i*LANE_W -: LANE_W];
        else           o_lane = i_block[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/aes_block_serializer.sv
// Pops BLOCK_W-bit words from a first-word-fall-through FIFO and streams them
// as LANE_W-bit lanes over a valid/ready link, back-to-back with no bubbles.
module aes_block_serializer
  import aes_pkg::*;
#(
  parameter int BLOCK_W   = AES_BLOCK_W,
  parameter int LANE_W    = AES_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [BLOCK_W-1:0] data,
  input  logic               empty,
  output logic               require,
  output logic               lane_valid,
  input  logic               lane_ready,
  output logic [LANE_W-1:0]  tx,
  output logic               sof,
  output logic               eof,
  output logic               lane_toggle,
  output logic               busy,
  output aes_state_e         dbg_state
);

  localparam int NLANES = lane_count(BLOCK_W, LANE_W);
  localparam int IDX_W  = $clog2(NLANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - 1);

  // Link handshake: a lane moves on a rising edge where en, lane_valid and
  // lane_ready are all high; tx/sof/eof hold while lane_valid waits on ready.
  aes_state_e          r_state;
  aes_state_e          w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [BLOCK_W-1:0]  r_block;
  logic                r_toggle;
  logic                w_pop;
  logic                w_xfer;
  logic                w_last;
  logic [LANE_W-1:0]   w_lane;

  aes_lane_sel #(
    .BLOCK_W  (BLOCK_W),
    .LANE_W   (LANE_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_lane_sel (
    .i_block(r_block),
    .i_idx  (r_idx),
    .o_lane (w_lane)
  );

  assign w_last = (r_idx == LAST_IDX);
  assign w_xfer = en & lane_valid & lane_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && !empty) begin
          w_pop       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_xfer) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + 1'b1;
          end else if (!empty) begin
            // Refill on the last-lane transfer so the next block starts
            // immediately.
            w_pop     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_block  <= '0;
      r_toggle <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop)  r_block  <= data;
      if (w_xfer) r_toggle <= ~r_toggle;
    end
  end

  // The pop is combinational from IDLE, so reset must mask it directly.
  assign require     = rst_n & w_pop;
  assign busy        = (r_state == SEND);
  assign lane_valid  = en & busy;
  assign tx          = busy ? w_lane : '0;
  assign sof         = lane_valid & (r_idx == '0);
  assign eof         = lane_valid & w_last;
  assign lane_toggle = r_toggle;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_aes_block_serializer.sv
// Bench for aes_block_serializer: byte-lane MSB-first instance plus a 32-bit
// LSB-first instance, FIFO models, lane scoreboard and directed scenarios.
module tb_aes_block_serializer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic lane_ready = 1'b1;

  logic [127:0] data8 = '0;
  logic         empty8 = 1'b1;
  logic         require8, lane_valid8, sof8, eof8, lane_toggle8, busy8;
  logic [7:0]   tx8;
  aes_state_e   dbg_state8;

  logic [127:0] data32 = '0;
  logic         empty32 = 1'b1;
  logic         require32, lane_valid32, sof32, eof32, lane_toggle32, busy32;
  logic [31:0]  tx32;
  aes_state_e   dbg_state32;

  always #5 clk = ~clk;

  aes_block_serializer #(.BLOCK_W(128), .LANE_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data8), .empty(empty8),
    .require(require8), .lane_valid(lane_valid8), .lane_ready(lane_ready),
    .tx(tx8), .sof(sof8), .eof(eof8), .lane_toggle(lane_toggle8),
    .busy(busy8), .dbg_state(dbg_state8)
  );

  aes_block_serializer #(.BLOCK_W(128), .LANE_W(32), .MSB_FIRST(1'b0)) dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data32), .empty(empty32),
    .require(require32), .lane_valid(lane_valid32), .lane_ready(lane_ready),
    .tx(tx32), .sof(sof32), .eof(eof32), .lane_toggle(lane_toggle32),
    .busy(busy32), .dbg_state(dbg_state32)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [127:0] fifo8_q[$];
  logic [127:0] fifo32_q[$];
  logic [9:0]   exp8_q[$];   // {sof, eof, tx}
  logic [33:0]  exp32_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int n_x8 = 0;
  int n_x32 = 0;
  initial begin
    logic [9:0]  e8;
    logic [33:0] e32;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp8_q.delete();
        exp32_q.delete();
        n_x8  = 0;
        n_x32 = 0;
      end else begin
        check("toggle8", 64'(lane_toggle8), 64'(n_x8 & 1));
        check("toggle32", 64'(lane_toggle32), 64'(n_x32 & 1));
        if (en && lane_valid8 && lane_ready) begin
          n_checks++;
          if (exp8_q.size() == 0) begin
            n_fails++;
            $display("FAIL lane8_unexpected: got %0h expected none", {sof8, eof8, tx8});
          end else begin
            e8 = exp8_q.pop_front();
            n_checks--;
            check("lane8", 64'({sof8, eof8, tx8}), 64'(e8));
          end
          n_x8++;
        end
        if (en && lane_valid32 && lane_ready) begin
          n_checks++;
          if (exp32_q.size() == 0) begin
            n_fails++;
            $display("FAIL lane32_unexpected: got %0h expected none", {sof32, eof32, tx32});
          end else begin
            e32 = exp32_q.pop_front();
            n_checks--;
            check("lane32", 64'({sof32, eof32, tx32}), 64'(e32));
          end
          n_x32++;
        end
      end
    end
  end

  // ---------------- driver side ----------------
  logic       s_req8, s_valid8, s_sof8, s_eof8, s_busy8, s_xfer8;
  logic [7:0] s_tx8;
  logic       s_req32, s_busy32, s_valid32;
  int cyc = 0;
  int n_req8, n_lanes8, n_valid8, first_v, last_v, n_bb, n_bb_eof;
  int n_req32, n_lanes32;

  task automatic clear_stats();
    n_req8 = 0; n_lanes8 = 0; n_valid8 = 0; first_v = -1; last_v = -1;
    n_bb = 0; n_bb_eof = 0; n_req32 = 0; n_lanes32 = 0;
  endtask

  task automatic drive_fifos();
    empty8  = (fifo8_q.size() == 0);
    data8   = empty8 ? '0 : fifo8_q[0];
    empty32 = (fifo32_q.size() == 0);
    data32  = empty32 ? '0 : fifo32_q[0];
  endtask

  function automatic logic [127:0] mk8(input logic [7:0] base);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = base + 8'(i);
    return b;
  endfunction

  task automatic push_exp8(input logic [7:0] base);
    for (int i = 0; i < 16; i++)
      exp8_q.push_back({(i == 0), (i == 15), 8'(base + 8'(i))});
  endtask

  task automatic push_block8(input logic [7:0] base);
    fifo8_q.push_back(mk8(base));
    push_exp8(base);
    drive_fifos();
  endtask

  // Sample everything at the negedge, then advance past the rising edge and
  // pop the FIFO model if the DUT requested.
  task automatic step();
    @(negedge clk);
    s_req8 = require8; s_valid8 = lane_valid8; s_tx8 = tx8; s_sof8 = sof8;
    s_eof8 = eof8; s_busy8 = busy8; s_xfer8 = en & lane_valid8 & lane_ready;
    s_req32 = require32; s_busy32 = busy32; s_valid32 = lane_valid32;
    cyc++;
    if (s_req8) n_req8++;
    if (s_xfer8) n_lanes8++;
    if (s_valid8) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      n_valid8++;
    end
    if (s_req8 && s_busy8) begin
      n_bb++;
      if (s_eof8 && s_xfer8) n_bb_eof++;
    end
    if (s_req32) n_req32++;
    if (en && lane_valid32 && lane_ready) n_lanes32++;
    @(posedge clk);
    #1;
    if (s_req8)  void'(fifo8_q.pop_front());
    if (s_req32) void'(fifo32_q.pop_front());
    drive_fifos();
  endtask

  task automatic run_until_idle(input string name, input int bound);
    bit done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      step();
      done = !s_busy8 && !s_valid8 && !s_req8 && !s_busy32 && !s_valid32 &&
             !s_req32 && fifo8_q.size() == 0 && fifo32_q.size() == 0;
    end
    if (!done) begin
      n_checks++; n_fails++;
      $display("FAIL %s_timeout: got busy expected idle within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_xfer8(input string name, input logic [7:0] lane);
    bit hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      step();
      hit = s_xfer8 && (s_tx8 == lane);
    end
    if (!hit) begin
      n_checks++; n_fails++;
      $display("FAIL %s_timeout: got no xfer expected tx=%0h", name, lane);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_out8"}, 64'({require8, lane_valid8, tx8, sof8, eof8, lane_toggle8, busy8}), 64'(0));
    check({name, "_out32"}, 64'({require32, lane_valid32, tx32, sof32, eof32, lane_toggle32, busy32}), 64'(0));
  endtask

  initial begin
    clear_stats();
    drive_fifos();

    // Reset state
    #23;
    check_outputs_zero("reset");
    check("reset_state", 64'(dbg_state8), 64'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 64'({s_req8, s_valid8, s_busy8}), 64'(0));

    // Single block, ready held high
    clear_stats();
    push_block8(8'h00);
    run_until_idle("single", 100);
    check("single_req", 64'(n_req8), 64'(1));
    check("single_lanes", 64'(n_lanes8), 64'(16));
    check("single_span", 64'(last_v - first_v + 1), 64'(16));
    check("single_busy_end", 64'(busy8), 64'(0));
    check("single_toggle_end", 64'(lane_toggle8), 64'(0));

    // Two queued blocks, back to back
    clear_stats();
    push_block8(8'h10);
    push_block8(8'h20);
    run_until_idle("b2b", 120);
    check("b2b_req", 64'(n_req8), 64'(2));
    check("b2b_lanes", 64'(n_valid8), 64'(32));
    check("b2b_span", 64'(last_v - first_v + 1), 64'(32));
    check("b2b_req_on_eof", 64'({n_bb, n_bb_eof}), {32'd1, 32'd1});

    // Backpressure for 3 cycles at lane 5
    clear_stats();
    push_block8(8'h00);
    wait_xfer8("bp", 8'h04);
    lane_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold", 64'({s_valid8, s_tx8, s_req8, s_sof8, s_eof8}), 64'({1'b1, 8'h05, 3'b000}));
    end
    lane_ready = 1'b1;
    step();
    check("bp_resume5", 64'({s_xfer8, s_tx8}), 64'({1'b1, 8'h05}));
    step();
    check("bp_resume6", 64'({s_xfer8, s_tx8}), 64'({1'b1, 8'h06}));
    run_until_idle("bp", 100);

    // Enable low for 4 cycles at lane 9
    clear_stats();
    push_block8(8'h00);
    wait_xfer8("en", 8'h08);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("en_gap", 64'({s_valid8, s_req8, s_sof8, s_eof8, s_busy8}), 64'(5'b00001));
    end
    en = 1'b1;
    step();
    check("en_resume9", 64'({s_xfer8, s_tx8}), 64'({1'b1, 8'h09}));
    run_until_idle("en", 100);
    check("en_lanes", 64'(n_lanes8), 64'(16));

    // Reset mid-block at lane 7
    clear_stats();
    push_block8(8'h00);
    wait_xfer8("rst", 8'h06);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    fifo8_q.push_back(mk8(8'h50));
    drive_fifos();
    #1;
    check("rst_no_pop", 64'(require8), 64'(0));
    step();
    check("rst_hold_no_pop", 64'(s_req8), 64'(0));
    rst_n = 1'b1;
    push_exp8(8'h50);
    step();
    check("rst_new_pop", 64'({s_req8, s_valid8}), 64'(2'b10));
    step();
    check("rst_new_sof", 64'({s_sof8, s_valid8, s_tx8}), 64'({2'b11, 8'h50}));
    run_until_idle("rst", 100);

    // 32-bit lanes, LSB first
    clear_stats();
    fifo32_q.push_back(128'h33333333_22222222_11111111_00000000);
    exp32_q.push_back({2'b10, 32'h00000000});
    exp32_q.push_back({2'b00, 32'h11111111});
    exp32_q.push_back({2'b00, 32'h22222222});
    exp32_q.push_back({2'b01, 32'h33333333});
    drive_fifos();
    run_until_idle("w32", 50);
    check("w32_req", 64'(n_req32), 64'(1));
    check("w32_lanes", 64'(n_lanes32), 64'(4));

    check("exp8_drained", 64'(exp8_q.size()), 64'(0));
    check("exp32_drained", 64'(exp32_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
